// File: rtl/alu_nibble_sequencer.sv
// Drives a 4-bit ALU one nibble per cycle, LSB first, chaining carry
// and assembling a 4*NIBBLES-bit result behind a start/done handshake.
module alu_nibble_sequencer #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [4*NIBBLES-1:0] op_a,
    input  logic [4*NIBBLES-1:0] op_b,
    input  logic [1:0]           op_sel,
    input  logic                 cin_in,
    output logic                 busy,
    output logic                 done,
    output logic [4*NIBBLES-1:0] result,
    output logic                 cout_out,
    output logic [3:0]           alu_A,
    output logic [3:0]           alu_B,
    output logic [1:0]           alu_S,
    output logic                 alu_Cin,
    input  logic [3:0]           alu_F,
    input  logic                 alu_Cout
);

    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [IW-1:0] idx;
    logic          carry;
    logic [W-1:0]  a_lat;
    logic [W-1:0]  b_lat;
    logic [1:0]    sel_lat;
    logic [W-1:0]  a_sh;
    logic [W-1:0]  b_sh;
    logic          last;

    assign last = (idx == IW'(NIBBLES - 1));
    assign a_sh = a_lat >> {idx, 2'b00};
    assign b_sh = b_lat >> {idx, 2'b00};

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand slices reach the ALU only while a nibble is in flight
    always_comb begin
        alu_A   = '0;
        alu_B   = '0;
        alu_Cin = 1'b0;
        alu_S   = sel_lat;
        if (state == RUN) begin
            alu_A   = a_sh[3:0];
            alu_B   = b_sh[3:0];
            alu_Cin = carry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            idx      <= '0;
            carry    <= 1'b0;
            a_lat    <= '0;
            b_lat    <= '0;
            sel_lat  <= '0;
            result   <= '0;
            cout_out <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt != IDLE);
            done  <= (state_nxt == DONE);
            unique case (state)
                IDLE: begin
                    if (start) begin
                        a_lat   <= op_a;
                        b_lat   <= op_b;
                        sel_lat <= op_sel;
                        carry   <= cin_in;
                        idx     <= '0;
                        result  <= '0;
                    end
                end
                RUN: begin
                    // result was cleared on start, so OR-ing in places the nibble
                    result <= result | (W'(alu_F) << {idx, 2'b00});
                    carry  <= alu_Cout;
                    if (last) begin
                        cout_out <= alu_Cout;
                        idx      <= '0;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                DONE: ;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Scoreboard bench: a 16-bit and a 4-bit sequencer, each wired to a
// behavioural 4-bit ALU, checked against whole-word reference arithmetic.
module tb_alu_nibble_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [31:0] r;
        logic        c;
        int          c0;
    } exp_t;

    exp_t q4[$];
    exp_t q1[$];
    logic cin_log[$];
    int done_cnt = 0;

    // 4-bit ALU: 00 AND (Cout 0), 01 OR (Cout 1), 10 XOR (Cout=Cin), 11 ADD
    function automatic logic [4:0] alu_fn(input logic [3:0] a, input logic [3:0] b,
                                          input logic [1:0] s, input logic c);
        logic [4:0] r;
        case (s)
            2'b00:   r = {1'b0, a & b};
            2'b01:   r = {1'b1, a | b};
            2'b10:   r = {c, a ^ b};
            default: r = {1'b0, a} + {1'b0, b} + {4'b0, c};
        endcase
        return r;
    endfunction

    // Whole-word reference: the carry chain collapses to plain arithmetic
    function automatic exp_t ref_op(input logic [31:0] a, input logic [31:0] b,
                                    input logic [1:0] s, input logic c, input int w);
        exp_t e;
        longint unsigned sum, mask;
        mask = (64'd1 << w) - 1;
        e.c0 = 0;
        case (s)
            2'b00: begin e.r = 32'((a & b) & mask); e.c = 1'b0; end
            2'b01: begin e.r = 32'((a | b) & mask); e.c = 1'b1; end
            2'b10: begin e.r = 32'((a ^ b) & mask); e.c = c; end
            default: begin
                sum = longint'(a & mask) + longint'(b & mask) + longint'(c);
                e.r = 32'(sum & mask);
                e.c = sum[w];
            end
        endcase
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // 16-bit instance
    logic        start4 = 1'b0;
    logic [15:0] a4 = '0, b4 = '0;
    logic [1:0]  sel4 = '0;
    logic        cin4 = 1'b0;
    logic        busy4, done4, cout4;
    logic [15:0] res4;
    logic [3:0]  aA4, aB4, aF4;
    logic [1:0]  aS4;
    logic        aCin4, aCout4;

    assign {aCout4, aF4} = alu_fn(aA4, aB4, aS4, aCin4);

    alu_nibble_sequencer #(.NIBBLES(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4),
        .op_a(a4), .op_b(b4), .op_sel(sel4), .cin_in(cin4),
        .busy(busy4), .done(done4), .result(res4), .cout_out(cout4),
        .alu_A(aA4), .alu_B(aB4), .alu_S(aS4), .alu_Cin(aCin4),
        .alu_F(aF4), .alu_Cout(aCout4)
    );

    // 4-bit instance
    logic       start1 = 1'b0;
    logic [3:0] a1 = '0, b1 = '0;
    logic [1:0] sel1 = '0;
    logic       cin1 = 1'b0;
    logic       busy1, done1, cout1;
    logic [3:0] res1;
    logic [3:0] aA1, aB1, aF1;
    logic [1:0] aS1;
    logic       aCin1, aCout1;

    assign {aCout1, aF1} = alu_fn(aA1, aB1, aS1, aCin1);

    alu_nibble_sequencer #(.NIBBLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1),
        .op_a(a1), .op_b(b1), .op_sel(sel1), .cin_in(cin1),
        .busy(busy1), .done(done1), .result(res1), .cout_out(cout1),
        .alu_A(aA1), .alu_B(aB1), .alu_S(aS1), .alu_Cin(aCin1),
        .alu_F(aF1), .alu_Cout(aCout1)
    );

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor for the 16-bit instance
    initial begin
        int brun;
        exp_t e;
        brun = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                brun = 0;
            end else begin
                brun = busy4 ? brun + 1 : 0;
                if (busy4 && !done4) cin_log.push_back(aCin4);
                if (done4) begin
                    done_cnt++;
                    if (q4.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done4: got done=1 expected no pending op");
                    end else begin
                        e = q4.pop_front();
                        chk("result4", 32'(res4), e.r);
                        chk("cout4", 32'(cout4), 32'(e.c));
                        chk("latency4", 32'(cyc - e.c0), 32'd4);
                        chk("busy_len4", 32'(brun), 32'd5);
                    end
                end
            end
        end
    end

    // Monitor for the 4-bit instance
    initial begin
        int brun;
        exp_t e;
        brun = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                brun = 0;
            end else begin
                brun = busy1 ? brun + 1 : 0;
                if (done1) begin
                    if (q1.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done1: got done=1 expected no pending op");
                    end else begin
                        e = q1.pop_front();
                        chk("result1", 32'(res1), e.r);
                        chk("cout1", 32'(cout1), 32'(e.c));
                        chk("latency1", 32'(cyc - e.c0), 32'd1);
                        chk("busy_len1", 32'(brun), 32'd2);
                    end
                end
            end
        end
    end

    // Issue one op; junk rewrites inputs and pulses start while busy
    task automatic run4(input logic [15:0] a, input logic [15:0] b,
                        input logic [1:0] s, input logic c, input bit junk);
        exp_t e;
        @(negedge clk);
        a4 = a; b4 = b; sel4 = s; cin4 = c; start4 = 1'b1;
        @(posedge clk);
        #1;
        e = ref_op(32'(a), 32'(b), s, c, 16);
        e.c0 = cyc;
        q4.push_back(e);
        chk("busy_after_start4", 32'(busy4), 32'd1);
        start4 = 1'b0;
        for (int i = 0; i <= 4; i++) begin
            @(negedge clk);
            if (junk) begin
                a4 = 16'($urandom); b4 = 16'($urandom);
                sel4 = 2'($urandom); cin4 = 1'($urandom);
                start4 = 1'($urandom);
            end
        end
        @(posedge clk);
        #1;
        start4 = 1'b0;
    endtask

    task automatic run1(input logic [3:0] a, input logic [3:0] b,
                        input logic [1:0] s, input logic c, input bit junk);
        exp_t e;
        @(negedge clk);
        a1 = a; b1 = b; sel1 = s; cin1 = c; start1 = 1'b1;
        @(posedge clk);
        #1;
        e = ref_op(32'(a), 32'(b), s, c, 4);
        e.c0 = cyc;
        q1.push_back(e);
        start1 = 1'b0;
        for (int i = 0; i <= 1; i++) begin
            @(negedge clk);
            if (junk) begin
                a1 = 4'($urandom); b1 = 4'($urandom);
                sel1 = 2'($urandom); cin1 = 1'($urandom);
                start1 = 1'($urandom);
            end
        end
        @(posedge clk);
        #1;
        start1 = 1'b0;
    endtask

    initial begin
        int d0;
        start4 = 1'b1;
        a4 = 16'hAAAA;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy4), 32'd0);
        chk("rst_done", 32'(done4), 32'd0);
        chk("rst_result", 32'(res4), 32'd0);
        chk("rst_cout", 32'(cout4), 32'd0);
        chk("rst_alu_A", 32'(aA4), 32'd0);
        chk("rst_alu_S", 32'(aS4), 32'd0);
        chk("rst_alu_Cin", 32'(aCin4), 32'd0);
        start4 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        run4(16'h1234, 16'h1111, 2'b11, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("result_hold", 32'(res4), 32'h2345);
        chk("idle_busy", 32'(busy4), 32'd0);

        cin_log.delete();
        run4(16'hFFFF, 16'h0001, 2'b11, 1'b0, 1'b0);
        chk("cin_log_len", 32'(cin_log.size()), 32'd4);
        if (cin_log.size() == 4) begin
            chk("cin_n0", 32'(cin_log[0]), 32'd0);
            chk("cin_n1", 32'(cin_log[1]), 32'd1);
            chk("cin_n2", 32'(cin_log[2]), 32'd1);
            chk("cin_n3", 32'(cin_log[3]), 32'd1);
        end

        run4(16'hFFFF, 16'hFFFF, 2'b11, 1'b1, 1'b0);

        d0 = done_cnt;
        run4(16'h0008, 16'h0008, 2'b11, 1'b0, 1'b1);
        chk("single_done", 32'(done_cnt - d0), 32'd1);

        // Abort mid-operation with an asynchronous reset
        @(negedge clk);
        a4 = 16'hFFFF; b4 = 16'h0001; sel4 = 2'b11; cin4 = 1'b0; start4 = 1'b1;
        @(posedge clk);
        #1;
        start4 = 1'b0;
        d0 = done_cnt;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy4), 32'd0);
        chk("abort_done", 32'(done4), 32'd0);
        chk("abort_result", 32'(res4), 32'd0);
        chk("abort_cout", 32'(cout4), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
        run4(16'h0F0F, 16'h00F1, 2'b11, 1'b1, 1'b0);

        for (int i = 0; i < 40; i++)
            run4(16'($urandom), 16'($urandom), 2'($urandom), 1'($urandom), 1'b1);
        for (int i = 0; i < 20; i++)
            run4(16'($urandom), 16'($urandom), 2'b11, 1'($urandom), 1'b1);

        run1(4'h5, 4'hA, 2'b11, 1'b0, 1'b0);
        run1(4'hF, 4'h1, 2'b11, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++)
            run1(4'($urandom), 4'($urandom), 2'($urandom), 1'($urandom), 1'b1);

        for (int i = 0; i < 20 && (q4.size() > 0 || q1.size() > 0); i++)
            @(posedge clk);
        #1;
        chk("q4_drained", 32'(q4.size()), 32'd0);
        chk("q1_drained", 32'(q1.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_nibble_sequencer.md
Name: alu_nibble_sequencer

Overview:
Multi-cycle controller that sits directly upstream of the 4-bit structural ALU (alu_4bit_struct) and consumes its outputs. It accepts a wide operation through a start/done handshake and drives the ALU one nibble per cycle, LSB nibble first. It chains the ALU's Cout back into Cin, assembles the wide result, and reports final carry-out. This gives the datapath 8/16/32-bit add capability from a single 4-bit ALU instance.

Parameters:
NIBBLES, 4, number of 4-bit slices per operation; operand width W = 4*NIBBLES; legal range 1..8

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
op_a  input  W  operand A
op_b  input  W  operand B
op_sel  input  2  ALU function code, passed verbatim to ALU S (2'b11 = ADD)
cin_in  input  1  carry into least-significant nibble
busy  output  1  high in RUN and DONE states
done  output  1  one-cycle pulse: result/cout_out valid
result  output  W  assembled ALU result
cout_out  output  1  ALU Cout of the last nibble
alu_A  output  4  to ALU A
alu_B  output  4  to ALU B
alu_S  output  2  to ALU S
alu_Cin  output  1  to ALU Cin
alu_F  input  4  from ALU F
alu_Cout  input  1  from ALU Cout

Behaviour:
- Reset (async, rst_n=0): state=IDLE, idx=0, carry=0, busy=0, done=0, result=0, cout_out=0, latched operands/op=0. Reset mid-operation aborts with no done pulse.
- States: IDLE -> RUN -> DONE -> IDLE.
- IDLE: if start=1 at edge E0, latch op_a, op_b, op_sel; set carry=cin_in, idx=0, clear result; go to RUN. start=0 keeps IDLE.
- RUN, ALU drive (combinational from registers):
  - alu_A = a_lat[4*idx+3:4*idx]
  - alu_B = b_lat[4*idx+3:4*idx]
  - alu_S = sel_lat
  - alu_Cin = carry
- RUN, each edge:
  - result[4*idx+3:4*idx] <= alu_F
  - carry <= alu_Cout
  - idx <= idx+1
- On the edge where idx = NIBBLES-1: also cout_out <= alu_Cout, done <= 1, state <= DONE, idx <= 0.
- DONE: lasts exactly one cycle; done=1 and busy=1; next edge: done <= 0, state <= IDLE.
- Latency: done is high in the cycle following edge E0+NIBBLES. A new start is accepted no earlier than edge E0+NIBBLES+1.
- Carry is always chained, regardless of op_sel. For non-ADD codes, cout_out reflects the last-nibble ALU Cout as produced.
- In IDLE and DONE, alu_A, alu_B and alu_Cin are driven 0; alu_S holds sel_lat.
- start while busy=1 (RUN or DONE) is ignored; latched operands are unchanged. Changing op_a/op_b/op_sel/cin_in during RUN has no effect.
- result and cout_out hold their final values after done until the next accepted start, which clears result.
- idx width = clog2(NIBBLES), minimum 1. For NIBBLES=1: RUN lasts one cycle, done follows E0 by one edge.
- No combinational path from start to done or busy; all status outputs are registered.

Test Plan:
(Bench instantiates this block connected to alu_4bit_struct; NIBBLES=4 unless noted; op_sel=2'b11.)
- op_a=16'h1234, op_b=16'h1111, cin_in=0, start pulse -> done after 4 RUN cycles; result=16'h2345, cout_out=0; busy high 5 cycles total.
- op_a=16'hFFFF, op_b=16'h0001, cin_in=0 -> carry ripples through all nibbles; result=16'h0000, cout_out=1; alu_Cin=0,1,1,1 on successive RUN cycles.
- op_a=16'hFFFF, op_b=16'hFFFF, cin_in=1 -> result=16'hFFFF, cout_out=1.
- Start 16'h0008+16'h0008; pulse start again with other operands during RUN and during DONE -> both ignored; result=16'h0010, cout_out=0, exactly one done pulse.
- Start 16'hFFFF+16'h0001; drive rst_n=0 after 2 RUN cycles -> busy, done, result, cout_out all 0 immediately (async); no done pulse; next start after release runs normally.
- NIBBLES=1: op_a=4'h5, op_b=4'hA, cin_in=0 -> done one edge after start; result=4'hF, cout_out=0.
